// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store sequencer and the writeback extension path.
package mem_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LB  = 3'b010,
        OP_LBU = 3'b110,
        OP_SW  = 3'b001,
        OP_SB  = 3'b011
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } seq_state_t;

    localparam int WORD_BEATS = 4;
    localparam int BYTE_BEATS = 1;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Turns an assembled little-endian load word into the architectural result for lw/lb/lbu.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  op,
    output logic [31:0] result
);

    // Stores and unknown codes yield zero so callers can latch the result unconditionally.
    always_comb begin
        result = '0;
        case (op)
            OP_LW:   result = word;
            OP_LB:   result = {{24{word[7]}}, word[7:0]};
            OP_LBU:  result = {24'b0, word[7:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_seq.sv
// Load/store sequencer: splits word and byte accesses into byte beats on an 8-bit memory port.
module mem_access_seq
    import mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 20,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_op,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     resp_valid,
    output logic [31:0]              resp_rdata,
    output logic                     resp_err,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    seq_state_t               state;
    seq_state_t               state_next;
    logic [2:0]               op;
    logic [ADDRESS_WIDTH-1:0] base;
    logic [31:0]              wdata;
    logic [1:0]               beat;
    logic [1:0]               last_beat;
    logic [31:0]              asm_word;
    logic [31:0]              asm_next;
    logic [31:0]              ext_word;
    logic [31:0]              rdata;
    logic                     err;
    logic                     is_store;

    wire unused_addr_bits = ^req_addr[31:ADDRESS_WIDTH];

    assign is_store  = op[0];
    assign last_beat = op[1] ? 2'(BYTE_BEATS - 1) : 2'(WORD_BEATS - 1);

    // Current memory byte merged into its lane; this is what the beat edge captures.
    always_comb begin
        asm_next = asm_word;
        asm_next[8*beat +: 8] = mem_rd;
    end

    load_extend u_load_extend (
        .word   (asm_next),
        .op     (op),
        .result (ext_word)
    );

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_we     = 1'b0;
        mem_wd     = '0;
        mem_addr   = '0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_next = op_legal(req_op) ? ST_ACCESS : ST_RESP;
            end
            ST_ACCESS: begin
                mem_addr = base + ADDRESS_WIDTH'(beat);
                if (is_store) begin
                    // Gated by reset so a beat interrupted by reset never commits.
                    mem_we = rst_n;
                    mem_wd = wdata[8*beat +: DATA_WIDTH];
                end
                if (beat == last_beat)
                    state_next = ST_RESP;
            end
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            op       <= '0;
            base     <= '0;
            wdata    <= '0;
            beat     <= '0;
            asm_word <= '0;
            err      <= 1'b0;
            rdata    <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op       <= req_op;
                        base     <= req_op[1] ? req_addr[ADDRESS_WIDTH-1:0]
                                              : {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
                        wdata    <= req_wdata;
                        beat     <= '0;
                        asm_word <= '0;
                        err      <= !op_legal(req_op);
                        if (!op_legal(req_op))
                            rdata <= '0;
                    end
                end
                ST_ACCESS: begin
                    asm_word <= asm_next;
                    beat     <= beat + 2'd1;
                    if (beat == last_beat)
                        rdata <= ext_word;
                end
                default: ;
            endcase
        end
    end

    assign resp_valid = (state == ST_RESP);
    assign resp_err   = (state == ST_RESP) && err;
    assign resp_rdata = rdata;

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: byte memory model plus an expected-response queue per scenario.
module tb_mem_access_seq;
    import mem_pkg::*;

    localparam int AW = 20;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wd;
    logic [7:0]    mem_rd;

    logic [7:0]    mem [0:(1<<AW)-1];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [7:0]    pre_data = '0;

    exp_t          exp_q[$];
    logic [AW-1:0] alog[$];
    logic [27:0]   wlog[$];
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    mem_access_seq #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    assign mem_rd = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wd;
        if (pre_en) mem[pre_addr] <= pre_data;
    end

    task automatic preset(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    // Issues one request and waits (bounded) for its response; lat = cycles after the accept edge.
    task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output logic er);
        alog.delete();
        wlog.delete();
        lat = -1;
        rd  = 'x;
        er  = 'x;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (resp_valid) begin
                lat = n;
                rd  = resp_rdata;
                er  = resp_err;
                break;
            end
            alog.push_back(mem_addr);
            if (mem_we) wlog.push_back({mem_addr, mem_wd});
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1)  begin n_bad++; $display("[TB] FAIL rst_ready got %b want 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_resp_valid got %b want 0", resp_valid); end
        n_cmp++; if (resp_err !== 1'b0)   begin n_bad++; $display("[TB] FAIL rst_resp_err got %b want 0", resp_err); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("[TB] FAIL rst_rdata got %h want 0", resp_rdata); end
        n_cmp++; if ({mem_we, mem_addr, mem_wd} !== 29'h0) begin n_bad++; $display("[TB] FAIL rst_mem got we=%b a=%h wd=%h want 0", mem_we, mem_addr, mem_wd); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1)  begin n_bad++; $display("[TB] FAIL post_rst_ready got %b want 1", req_ready); end
    endtask

    task automatic test_word;
        int lat; logic [31:0] rd; logic er; exp_t e;
        logic [31:0] wd = 32'hDEADBEEF;
        exp_q.push_back('{32'h0, 1'b0, 5});
        run_req(OP_SW, 32'h00104, wd, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++; if ({rd, er} !== {e.rdata, e.err}) begin n_bad++; $display("[TB] FAIL sw_resp got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("[TB] FAIL sw_lat got %0d want %0d", lat, e.lat); end
        n_cmp++; if (wlog.size() !== 4) begin n_bad++; $display("[TB] FAIL sw_beats got %0d want 4", wlog.size()); end
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            n_cmp++;
            if (wlog[i] !== {AW'(32'h104 + i), wd[8*i +: 8]}) begin
                n_bad++; $display("[TB] FAIL sw_beat%0d got %h want %h", i, wlog[i], {AW'(32'h104 + i), wd[8*i +: 8]});
            end
        end

        exp_q.push_back('{32'hDEADBEEF, 1'b0, 5});
        run_req(OP_LW, 32'h00104, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++; if ({rd, er} !== {e.rdata, e.err}) begin n_bad++; $display("[TB] FAIL lw_resp got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("[TB] FAIL lw_lat got %0d want %0d", lat, e.lat); end

        exp_q.push_back('{32'hDEADBEEF, 1'b0, 5});
        run_req(OP_LW, 32'h00106, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++; if ({rd, er, lat} !== {e.rdata, e.err, e.lat}) begin n_bad++; $display("[TB] FAIL lw_unaligned got %h/%b/%0d want %h/%b/%0d", rd, er, lat, e.rdata, e.err, e.lat); end
        for (int i = 0; i < 4 && i < alog.size(); i++) begin
            n_cmp++;
            if (alog[i] !== AW'(32'h104 + i)) begin n_bad++; $display("[TB] FAIL lw_unaligned_addr%0d got %h want %h", i, alog[i], AW'(32'h104 + i)); end
        end
    endtask

    task automatic test_byte;
        int lat; logic [31:0] rd; logic er; exp_t e;
        exp_q.push_back('{32'hFFFFFF80, 1'b0, 2});
        run_req(OP_LB, 32'h00010, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++; if ({rd, er, lat} !== {e.rdata, e.err, e.lat}) begin n_bad++; $display("[TB] FAIL lb got %h/%b/%0d want %h/%b/%0d", rd, er, lat, e.rdata, e.err, e.lat); end
        @(negedge clk);
        n_cmp++; if ({resp_valid, resp_rdata} !== {1'b0, 32'hFFFFFF80}) begin n_bad++; $display("[TB] FAIL lb_hold got %b/%h want 0/ffffff80", resp_valid, resp_rdata); end

        exp_q.push_back('{32'h00000080, 1'b0, 2});
        run_req(OP_LBU, 32'h00010, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++; if ({rd, er, lat} !== {e.rdata, e.err, e.lat}) begin n_bad++; $display("[TB] FAIL lbu got %h/%b/%0d want %h/%b/%0d", rd, er, lat, e.rdata, e.err, e.lat); end

        exp_q.push_back('{32'h0, 1'b0, 2});
        run_req(OP_SB, 32'h00010, 32'h12345678, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++; if ({rd, er, lat} !== {e.rdata, e.err, e.lat}) begin n_bad++; $display("[TB] FAIL sb got %h/%b/%0d want %h/%b/%0d", rd, er, lat, e.rdata, e.err, e.lat); end
        n_cmp++; if (wlog.size() !== 1 || wlog[0] !== {AW'(32'h10), 8'h78}) begin n_bad++; $display("[TB] FAIL sb_write got %0d writes want 1 of 00010/78", wlog.size()); end
        @(negedge clk);
        n_cmp++; if ({mem[20'h10], mem[20'h11]} !== 16'h7833) begin n_bad++; $display("[TB] FAIL sb_mem got %h%h want 7833", mem[20'h10], mem[20'h11]); end
    endtask

    task automatic test_illegal;
        int lat; logic [31:0] rd; logic er; exp_t e;
        exp_q.push_back('{32'h0, 1'b1, 1});
        run_req(3'b101, 32'h00104, 32'hFFFFFFFF, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++; if ({rd, er, lat} !== {e.rdata, e.err, e.lat}) begin n_bad++; $display("[TB] FAIL illegal got %h/%b/%0d want %h/%b/%0d", rd, er, lat, e.rdata, e.err, e.lat); end
        n_cmp++; if (wlog.size() !== 0 || mem_we !== 1'b0) begin n_bad++; $display("[TB] FAIL illegal_we got %0d writes want 0", wlog.size()); end
        @(negedge clk);
        n_cmp++; if ({resp_valid, resp_err, req_ready} !== 3'b001) begin n_bad++; $display("[TB] FAIL illegal_after got %b want 001", {resp_valid, resp_err, req_ready}); end
    endtask

    task automatic test_reset_mid;
        int resp_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_SW;
        req_addr  = 32'h00200;
        req_wdata = 32'hAABBCCDD;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if ({req_ready, resp_valid, mem_we} !== 3'b100) begin n_bad++; $display("[TB] FAIL midrst_state got %b want 100", {req_ready, resp_valid, mem_we}); end
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (resp_valid) resp_cnt++;
            @(negedge clk);
        end
        n_cmp++; if (resp_cnt !== 0) begin n_bad++; $display("[TB] FAIL midrst_resp got %0d want 0", resp_cnt); end
        n_cmp++; if ({mem[20'h200], mem[20'h201], mem[20'h202], mem[20'h203]} !== 32'hDDCC3344) begin
            n_bad++; $display("[TB] FAIL midrst_mem got %h%h%h%h want ddcc3344", mem[20'h200], mem[20'h201], mem[20'h202], mem[20'h203]);
        end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL midrst_ready got %b want 1", req_ready); end
    endtask

    task automatic test_back_to_back;
        int acc2 = -1;
        int nresp = 0;
        int lat; logic [31:0] rd; logic er; exp_t e;
        exp_q.push_back('{32'hDEADBEEF, 1'b0, 5});
        exp_q.push_back('{32'hC35A3378, 1'b0, 11});
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_LW;
        req_addr  = 32'h00104;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) req_addr = 32'h00010;
            if (acc2 >= 0) req_valid = 1'b0;
            if (resp_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                nresp++;
                n_cmp++; if ({resp_rdata, resp_err, n} !== {e.rdata, e.err, e.lat}) begin n_bad++; $display("[TB] FAIL b2b_resp%0d got %h/%b/%0d want %h/%b/%0d", nresp, resp_rdata, resp_err, n, e.rdata, e.err, e.lat); end
            end
            if (req_ready && req_valid && acc2 < 0) acc2 = n;
        end
        req_valid = 1'b0;
        n_cmp++; if (acc2 !== 6) begin n_bad++; $display("[TB] FAIL b2b_accept got %0d want 6", acc2); end
        n_cmp++; if (nresp !== 2) begin n_bad++; $display("[TB] FAIL b2b_count got %0d want 2", nresp); exp_q.delete(); end

        exp_q.push_back('{32'hFFFFFFA5, 1'b0, 2});
        run_req(OP_LB, 32'h000FFFFF, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++; if ({rd, er, lat} !== {e.rdata, e.err, e.lat}) begin n_bad++; $display("[TB] FAIL lb_top got %h/%b/%0d want %h/%b/%0d", rd, er, lat, e.rdata, e.err, e.lat); end
        n_cmp++; if (alog.size() < 1 || alog[0] !== 20'hFFFFF) begin n_bad++; $display("[TB] FAIL lb_top_addr want fffff"); end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'b000;
        req_addr  = '0;
        req_wdata = '0;
        preset(20'h00010, 8'h80);
        preset(20'h00011, 8'h33);
        preset(20'h00012, 8'h5A);
        preset(20'h00013, 8'hC3);
        preset(20'hFFFFF, 8'hA5);
        preset(20'h00200, 8'h11);
        preset(20'h00201, 8'h22);
        preset(20'h00202, 8'h33);
        preset(20'h00203, 8'h44);
        test_reset();
        test_word();
        test_byte();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Initiator-side load/store sequencer between the pipeline MEM stage and a byte-wide data memory port (asynchronous byte read, synchronous byte write). It accepts one load/store request at a time using the pipeline's 3-bit memory-op encoding. Word ops run as four little-endian byte beats, byte ops as one beat. Load results are sign- or zero-extended and returned with a single-cycle response pulse.

## Interface
- ADDRESS_WIDTH, 20, memory byte-address width; memory holds 2**ADDRESS_WIDTH bytes
- DATA_WIDTH, 8, memory port width in bits; fixed at 8
- clk  in  1  sole clock; all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  pipeline request strobe
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
- req_op  in  3  3'b000 lw, 3'b010 lb, 3'b110 lbu, 3'b001 sw, 3'b011 sb; all other codes illegal
- req_addr  in  32  byte address; only bits [ADDRESS_WIDTH-1:0] used
- req_wdata  in  32  store data
- resp_valid  out  1  one-cycle pulse marking completion
- resp_rdata  out  32  load result; 0 for stores and errors; held until next resp_valid
- resp_err  out  1  valid with resp_valid; 1 = illegal op
- mem_addr  out  ADDRESS_WIDTH  byte address to memory
- mem_we  out  1  byte write enable, sampled by memory at posedge
- mem_wd  out  8  write byte
- mem_rd  in  8  read byte, combinational from mem_addr

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On accept, latch op, address and wdata.
  - Clear the beat counter (2 bits) and the load assembly register.
  - Go to ACCESS; illegal op goes straight to RESP with the error flag set.
- Base address:
  - Word ops (op[1]=0): {req_addr[ADDRESS_WIDTH-1:2], 2'b00}; low address bits are silently dropped.
  - Byte ops: req_addr[ADDRESS_WIDTH-1:0].
- ACCESS, each cycle:
  - mem_addr = base + beat, computed modulo 2**ADDRESS_WIDTH.
  - Stores: mem_we=1, mem_wd = wdata byte [8*beat+7 : 8*beat].
  - Loads: mem_we=0; mem_rd is captured into byte lane beat at the posedge.
- Beat count: last beat is 3 for word ops and 0 for byte ops. After the last beat, go to RESP.
- RESP:
  - resp_valid=1 for one cycle, then IDLE.
  - resp_rdata per op: lw = assembled word; lb = {{24{b[7]}}, b}; lbu = {24'b0, b}; stores and errors = 0.
- Outside ACCESS: mem_we=0, mem_wd=0, mem_addr=0.

## Timing
- Accept occurs at posedge T0.
- lw/sw: beats in cycles T0+1..T0+4; resp_valid in cycle T0+5; req_ready again in T0+6.
- lb/lbu/sb: beat in T0+1; resp in T0+2.
- Illegal op: resp in T0+1 with resp_err=1; no memory beat.
- Store bytes commit at the end of each beat cycle. Load bytes are sampled at the end of each beat cycle.
- resp_valid and resp_err are registered state decodes and never glitch high outside RESP.
- req_valid while busy is ignored; the request must be held until accepted.
- Wrap-around:
  - A word base is aligned, so a word never straddles the top of memory.
  - A byte at address 2**ADDRESS_WIDTH-1 is legal.
- Reset values: state IDLE, req_ready=1 on the first cycle after reset, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wd=0.
- Reset mid-operation:
  - Returns to IDLE at that posedge; no response is issued.
  - Bytes already written remain in memory.
  - mem_we is low from the reset edge onward.

## Structure
- Shared package mem_pkg:
  - mem_op_t enum (OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB with the codes above).
  - State enum.
  - Constants WORD_BEATS=4 and BYTE_BEATS=1.
- Sub-module: load_extend, a combinational word/lb/lbu extension on the assembled word and op. It is shared with the pipeline writeback path.
- The FSM, beat counter and latched request stay in mem_access_seq.

## Test plan
- sw 0xDEADBEEF at 0x00104, then lw 0x00104:
  - Write beats: mem_addr 0x104..0x107 with mem_wd EF, BE, AD, DE.
  - resp_rdata=0xDEADBEEF at T0+5.
- lw at 0x00106 → beats at 0x104..0x107; unaligned low bits are ignored.
- With byte 0x80 at 0x00010:
  - lb → 0xFFFFFF80 at T0+2.
  - lbu → 0x00000080.
  - sb 0x12345678 at 0x00010 writes only 0x78.
- req_op=3'b101 → resp_valid with resp_err=1 and resp_rdata=0 at T0+1; mem_we never asserted.
- rst_n low during beat 2 of an sw:
  - IDLE the next cycle; no resp_valid.
  - Bytes 0 and 1 are written, bytes 2 and 3 are unchanged.
  - req_ready=1 after reset.
- Back-to-back: req_valid held high across two lw requests → the second is accepted only when req_ready returns high (T0+6); lb at 0xFFFFF returns the top memory byte.
